// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and helpers for the UART transmit controller.
// State encoding, clog2 and default baud divider.
package uart_tx_ctrl_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int unsigned clog2(
    input int unsigned v
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: one-cycle tick on the last clock of each serial bit.
// Synchronous clear realigns the bit grid to a new frame.
module uart_bit_timer
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte handshake in, framed LSB-first serial out.
// tx and tx_ready are registered so the line only moves on bit boundaries.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BW = clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d;
  logic rdy_q, rdy_d;
  logic accept, tick, timer_en;

  assign accept   = tx_valid && rdy_q;
  assign timer_en = (state_q != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (timer_en),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          bit_d   = '0;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_DATA) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        // bit counter is reused to count stop bits
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            bit_d   = '0;
            rdy_d   = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = rdy_q;
  assign busy     = !rdy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: accepts queue expected frames,
// a negedge monitor checks every serial cycle against a frame model.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int NF  = (1 + DB + SB) * CPB;
  localparam int CPB2 = 2;
  localparam int DB2  = 7;
  localparam int SB2  = 2;
  localparam int NF2  = (1 + DB2 + SB2) * CPB2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data;
  logic tx_valid, tx_ready, tx, busy;
  logic [6:0] b_data;
  logic b_valid, b_ready, b_tx, b_busy;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .busy    (busy)
  );

  uart_tx_ctrl #(
    .CLKS_PER_BIT(CPB2),
    .DATA_BITS   (DB2),
    .STOP_BITS   (SB2)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (b_data),
    .tx_valid(b_valid),
    .tx_ready(b_ready),
    .tx      (b_tx),
    .busy    (b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t q[$];
  exp_t e;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Line level k cycles after an accept: start, data LSB-first, stops.
  function automatic logic exp_bit(
    input logic [8:0] d, input int k, input int cpb, input int db
  );
    int idx;
    idx = k / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= db) return d[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && tx_valid && tx_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      q.push_back('{tx_data, cyc});
    end
  end

  logic in_frame = 1'b0;
  logic chk_rdy = 1'b0;
  int k = 0;
  logic [7:0] cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      chk_rdy  = 1'b0;
    end else begin
      if (!in_frame && q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        cur = e.d;
        in_frame = 1'b1;
        k = 0;
      end
      if (in_frame) begin
        chk("frame_bit", {tx, tx_ready, busy},
            {exp_bit({1'b0, cur}, k, CPB, DB), 2'b01});
        k++;
        if (k == NF) begin
          in_frame = 1'b0;
          chk_rdy = 1'b1;
        end
      end else if (chk_rdy) begin
        chk("ready_back", {tx, tx_ready, busy}, 3'b110);
        chk_rdy = 1'b0;
      end else begin
        chk("idle_line", tx, 1);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d);
    wait_ready();
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
  endtask

  initial begin
    int a, base, first;
    logic [7:0] d;
    tx_valid = 1'b1;
    tx_data = 8'($urandom);
    b_valid = 1'b0;
    b_data = '0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", {tx, tx_ready, busy}, 3'b110);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("accept_after_reset", acc_cnt, 1);
    tx_valid = 1'b0;
    wait_ready();

    send(8'hA5);
    a = acc_cyc;
    wait_ready();
    chk("frame_len", cyc - a, NF);

    @(negedge clk);
    base = acc_cnt;
    first = -1;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (acc_cnt > base) begin
        if (first < 0) first = acc_cyc;
        tx_data = 8'hFF;
      end
    end
    tx_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - base, 2);
    chk("b2b_gap", acc_cyc - first, NF + 1);
    wait_ready();

    send(8'h3C);
    base = acc_cnt;
    repeat (5) @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_ignored", acc_cnt - base, 0);
    wait_ready();

    d = 8'($urandom) & 8'hF7;
    send(d);
    a = acc_cyc;
    while (cyc < a + 17) @(negedge clk);
    chk("bit3_low", tx, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {tx, tx_ready, busy}, 3'b110);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_idle", {tx, tx_ready, busy}, 3'b110);
    send(8'h81);
    wait_ready();

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        base = acc_cnt;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("rand_busy_ignored", acc_cnt - base, 0);
      end
    end
    wait_ready();

    @(negedge clk);
    chk("sweep_idle", b_ready, 1);
    b_data = 7'h55;
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int j = 0; j < NF2; j++) begin
      chk("sweep_bit", {b_tx, b_ready},
          {exp_bit(9'h055, j, CPB2, DB2), 1'b0});
      @(negedge clk);
    end
    chk("sweep_ready_back", {b_tx, b_ready}, 2'b11);

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
